rgb444_upscale_filter: RTL and testbench

//  Downstream of QVGA_MemController: turns the 2x-replicated QVGA stream (each 320x240 source

---
 rtl/rgb444_upscale_filter_if.sv | 22 ++
 rtl/rgb444_upscale_filter.sv | 100 ++++++++++
 tb/tb_rgb444_upscale_filter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rgb444_upscale_filter_if.sv
// Video stream bundle between the VGA timing source and the upscale filter.
interface rgb444_upscale_filter_if;
  logic        display_en;
  logic [9:0]  x_coor;
  logic [9:0]  y_coor;
  logic        hsync_i;
  logic        vsync_i;
  logic [11:0] rgb_i;
  logic [11:0] rgb_o;
  logic        de_o;
  logic        hsync_o;
  logic        vsync_o;

  modport master (
    output display_en, x_coor, y_coor, hsync_i, vsync_i, rgb_i,
    input  rgb_o, de_o, hsync_o, vsync_o
  );
  modport slave (
    input  display_en, x_coor, y_coor, hsync_i, vsync_i, rgb_i,
    output rgb_o, de_o, hsync_o, vsync_o
  );
endinterface

// File: rtl/rgb444_upscale_filter.sv
// Smooths a 2x-replicated QVGA stream into 640x480 RGB444: 2-tap horizontal
// average, then 2-tap vertical average against the previous line's result.
module rgb444_upscale_filter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LATENCY  = 2
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_tick,
  input  logic                   filter_en,
  rgb444_upscale_filter_if.slave vid
);
  localparam logic [9:0] X_END  = 10'(H_ACTIVE);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_END  = 10'(V_ACTIVE);

  function automatic logic [11:0] avg(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    logic [4:0]  s;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = {1'b0, a[4*c +: 4]} + {1'b0, b[4*c +: 4]};
      r[4*c +: 4] = s[4:1];
    end
    return r;
  endfunction

  logic        act, frame_start, filt_now;
  logic [11:0] prev, h, last_rgb;
  logic        synced, filt_frame, line_valid;
  logic        act1, top1, filt1;
  logic [9:0]  x1;
  logic [11:0] h1, raw1;
  logic [11:0] u, v, pix, rgb_r;
  logic [LATENCY-1:0][2:0] sync_sr;
  logic [11:0] linebuf [H_ACTIVE];

  // stage 1: horizontal tap; the line start averages a pixel with itself
  always_comb begin
    act         = vid.display_en && (vid.x_coor < X_END) && (vid.y_coor < Y_END);
    frame_start = act && (vid.x_coor == '0) && (vid.y_coor == '0);
    prev        = (vid.x_coor == '0) ? vid.rgb_i : last_rgb;
    h           = avg(vid.rgb_i, prev);
    // before the first frame start after reset there is no latched mode yet
    filt_now    = (frame_start || !synced) ? filter_en : filt_frame;
  end

  // stage 2: vertical tap against the line buffer (read before write)
  always_comb begin
    u   = linebuf[x1];
    v   = (top1 || !line_valid) ? h1 : avg(h1, u);
    pix = filt1 ? v : raw1;
  end

  always_ff @(posedge clk) begin
    if (!reset && pix_tick && act1) linebuf[x1] <= h1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_sr    <= '0;
      last_rgb   <= '0;
      synced     <= 1'b0;
      filt_frame <= 1'b0;
      line_valid <= 1'b0;
      act1       <= 1'b0;
      top1       <= 1'b0;
      filt1      <= 1'b0;
      x1         <= '0;
      h1         <= '0;
      raw1       <= '0;
      rgb_r      <= '0;
    end else if (pix_tick) begin
      sync_sr <= {sync_sr[LATENCY-2:0], {vid.display_en, vid.hsync_i, vid.vsync_i}};
      if (act) last_rgb <= vid.rgb_i;
      if (frame_start) begin
        synced     <= 1'b1;
        filt_frame <= filter_en;
      end
      act1  <= act;
      top1  <= (vid.y_coor == '0);
      x1    <= act ? vid.x_coor : '0;
      h1    <= h;
      raw1  <= vid.rgb_i;
      filt1 <= filt_now;
      rgb_r <= act1 ? pix : '0;
      // vertical history becomes usable once a whole line of the current frame is stored
      if (act1) begin
        if (top1 && (x1 == '0))            line_valid <= 1'b0;
        else if ((x1 == X_LAST) && synced) line_valid <= 1'b1;
      end
    end
  end

  assign vid.rgb_o   = rgb_r;
  assign vid.de_o    = sync_sr[LATENCY-1][2];
  assign vid.hsync_o = sync_sr[LATENCY-1][1];
  assign vid.vsync_o = sync_sr[LATENCY-1][0];
endmodule

// File: tb/tb_rgb444_upscale_filter.sv
// Drives small frames (columns 0..4 plus 639) and checks against a per-frame image model.
module tb_rgb444_upscale_filter;
  localparam int NR = 4;
  localparam int NC = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_tick = 1'b0;
  logic filter_en = 1'b0;
  int   ph = 0, cyc = 0;
  int   errors = 0, checks = 0;
  int   c_hs_in = 0, c_hs_out = 0, c_de_in = 0, c_de_out = 0;
  logic hs_q = 1'b0, de_q = 1'b0;
  logic [11:0] held_rgb = '0;
  logic        held_de = 1'b0;
  logic [14:0] expq [$];
  logic [11:0] img [NR][NC];

  rgb444_upscale_filter_if vid();

  rgb444_upscale_filter dut (
    .clk      (clk),
    .reset    (reset),
    .pix_tick (pix_tick),
    .filter_en(filter_en),
    .vid      (vid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ph       <= (ph + 1) % 4;
    pix_tick <= (ph == 2);
    cyc      <= cyc + 1;
  end

  always @(negedge clk) begin
    hs_q <= vid.hsync_o;
    de_q <= vid.de_o;
    if (vid.hsync_o && !hs_q) c_hs_out <= cyc;
    if (vid.de_o && !de_q)    c_de_out <= cyc;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] avg(input logic [11:0] a, input logic [11:0] b);
    int ca, cb;
    logic [11:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ca = (int'(a) >> (4 * c)) & 15;
      cb = (int'(b) >> (4 * c)) & 15;
      r  = r | 12'(((ca + cb) / 2) << (4 * c));
    end
    return r;
  endfunction

  function automatic int colx(input int i);
    return (i == NC - 1) ? 639 : i;
  endfunction

  function automatic logic [11:0] hmod(input int y, input int i);
    return avg(img[y][i], (i == 0) ? img[y][i] : img[y][i-1]);
  endfunction

  // row 0 ends at column 639, so every later row blends with the row above
  function automatic logic [11:0] vmod(input int y, input int i);
    return (y == 0) ? hmod(y, i) : avg(hmod(y, i), hmod(y - 1, i));
  endfunction

  task automatic tick_drive(input bit de, input int x, input int y, input bit hs,
                            input bit vs, input logic [11:0] rgb, input bit fe,
                            input logic [11:0] erg);
    logic [14:0] e;
    do @(negedge clk); while (!pix_tick);
    chk("hold_rgb", int'(vid.rgb_o), int'(held_rgb));
    chk("hold_de", int'(vid.de_o), int'(held_de));
    @(posedge clk); #1;
    if (expq.size() >= 2) begin
      e = expq.pop_front();
      chk("rgb", int'(vid.rgb_o), int'(e[11:0]));
      chk("de", int'(vid.de_o), int'(e[14]));
      chk("hsync", int'(vid.hsync_o), int'(e[13]));
      chk("vsync", int'(vid.vsync_o), int'(e[12]));
    end
    held_rgb = vid.rgb_o;
    held_de  = vid.de_o;
    vid.display_en = de;
    vid.x_coor     = 10'(x);
    vid.y_coor     = 10'(y);
    vid.hsync_i    = hs;
    vid.vsync_i    = vs;
    vid.rgb_i      = rgb;
    filter_en      = fe;
    expq.push_back({de, hs, vs, de ? erg : 12'h000});
  endtask

  task automatic blank(input bit hs, input bit vs, input bit fe);
    tick_drive(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023), hs, vs,
               12'($urandom), fe, 12'h000);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rgb"}, int'(vid.rgb_o), 0);
    chk({tag, "_de"}, int'(vid.de_o), 0);
    chk({tag, "_hs"}, int'(vid.hsync_o), 0);
    chk({tag, "_vs"}, int'(vid.vsync_o), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_zero("rst_next");
    vid.display_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    reset = 1'b0;
    expq.delete();
    held_rgb = '0;
    held_de  = 1'b0;
  endtask

  // pat: 0 random, 1 2x2 checker F00/000, 2 row0 F00,F00,0F0,0F0, 3 rows 0F0/00F
  task automatic run_frame(input int pat, input bit fe0, input int tog_row, input int rst_row);
    bit fe;
    logic [11:0] e;
    for (int y = 0; y < NR; y++)
      for (int i = 0; i < NC; i++) begin
        img[y][i] = 12'($urandom);
        case (pat)
          1: img[y][i] = (((colx(i) / 2) + (y / 2)) % 2 == 0) ? 12'hF00 : 12'h000;
          2: if (y == 0 && i < 4) img[y][i] = (i < 2) ? 12'hF00 : 12'h0F0;
          3: img[y][i] = (y < 2) ? 12'h0F0 : 12'h00F;
          default: ;
        endcase
      end
    fe = fe0;
    blank(1'b0, 1'b1, fe);
    blank(1'b0, 1'b1, fe);
    blank(1'b0, 1'b0, fe);
    for (int y = 0; y < NR; y++) begin
      if (y == 2) begin
        chk("hs_lag_clk", c_hs_out - c_hs_in, 8);
        chk("de_lag_clk", c_de_out - c_de_in, 8);
      end
      if (y == tog_row) fe = !fe0;
      blank(1'b1, 1'b0, fe);
      if (y == 1) c_hs_in = cyc;
      blank(1'b1, 1'b0, fe);
      blank(1'b0, 1'b0, fe);
      for (int i = 0; i < NC; i++) begin
        if (y == rst_row && i == 4) begin
          do_reset();
          return;
        end
        e = fe0 ? vmod(y, i) : img[y][i];
        tick_drive(1'b1, colx(i), y, 1'b0, 1'b0, img[y][i], fe, e);
        if (y == 1 && i == 0) c_de_in = cyc;
      end
    end
  endtask

  initial begin
    vid.display_en = 1'b0;
    vid.x_coor     = '0;
    vid.y_coor     = '0;
    vid.hsync_i    = 1'b0;
    vid.vsync_i    = 1'b0;
    vid.rgb_i      = '0;
    repeat (5) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    run_frame(2, 1'b1, -1, -1);
    run_frame(1, 1'b0, -1, -1);
    run_frame(3, 1'b1, -1, -1);
    run_frame(0, 1'b1, 2, -1);
    run_frame(0, 1'b0, -1, -1);
    run_frame(0, 1'b1, -1, 1);
    run_frame(0, 1'b1, -1, -1);
    for (int k = 0; k < 4; k++) run_frame(0, 1'($urandom_range(0, 1)), -1, -1);

    // illegal coordinates with display_en high give black but keep DE
    tick_drive(1'b1, 700, 1, 1'b0, 1'b0, 12'hABC, filter_en, 12'h000);
    tick_drive(1'b1, 3, 480, 1'b0, 1'b0, 12'h5A5, filter_en, 12'h000);
    repeat (3) blank(1'b0, 1'b0, filter_en);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
